// File: rtl/logic_gate_checker_pkg.sv
// Shared encodings for the gate checker: gate selection codes, expected
// truth tables (bit index = {A,B}) and the sequencing FSM states.
package logic_gate_checker_pkg;

    typedef enum logic [2:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_NAND = 3'd2,
        GATE_NOR  = 3'd3,
        GATE_XOR  = 3'd4,
        GATE_XNOR = 3'd5,
        GATE_NOTA = 3'd6,
        GATE_BUFA = 3'd7
    } gate_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_NOTA = 4'b0011;
    localparam logic [3:0] TT_BUFA = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/gate_truth_rom.sv
// Combinational lookup of the expected 4-entry truth table for a gate code.
module gate_truth_rom
    import logic_gate_checker_pkg::*;
(
    input  logic [2:0] gate_sel,
    output logic [3:0] expected_tbl
);

    always_comb begin
        expected_tbl = TT_AND;
        case (gate_e'(gate_sel))
            GATE_AND:  expected_tbl = TT_AND;
            GATE_OR:   expected_tbl = TT_OR;
            GATE_NAND: expected_tbl = TT_NAND;
            GATE_NOR:  expected_tbl = TT_NOR;
            GATE_XOR:  expected_tbl = TT_XOR;
            GATE_XNOR: expected_tbl = TT_XNOR;
            GATE_NOTA: expected_tbl = TT_NOTA;
            GATE_BUFA: expected_tbl = TT_BUFA;
            default:   expected_tbl = TT_AND;
        endcase
    end

endmodule

// File: rtl/logic_gate_checker.sv
// Exhaustive two-input gate tester: drives all four {A,B} vectors, samples the
// external gate output after a settle time and compares against the truth table.
//
// state  | meaning
// IDLE   | waiting for start, results held
// SETTLE | vector applied, settle down-counter running
// SAMPLE | one cycle, dut_y captured and compared at the closing edge
// DONE   | one-cycle done pulse, pass valid
module logic_gate_checker
    import logic_gate_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] y_table,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] gate_q, gate_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] y_q, y_d;
    logic [3:0] fm_q, fm_d;
    logic [2:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       dut_a_q, dut_a_d;
    logic       dut_b_q, dut_b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] expected_tbl;
    logic       mism;
    logic [2:0] err_nxt;

    gate_truth_rom u_rom (
        .gate_sel     (gate_q),
        .expected_tbl (expected_tbl)
    );

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        fm_d    = fm_q;
        err_d   = err_q;
        pass_d  = pass_q;
        mism    = dut_y ^ expected_tbl[idx_q];
        err_nxt = err_q + {2'b00, mism};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gate_d  = gate_sel;
                    y_d     = 4'b0000;
                    fm_d    = 4'b0000;
                    err_d   = 3'd0;
                    pass_d  = 1'b0;
                    idx_d   = 2'd0;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                y_d[idx_q]  = dut_y;
                fm_d[idx_q] = mism;
                err_d       = err_nxt;
                if (idx_q == 2'd3) begin
                    pass_d  = (err_nxt == 3'd0);
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        busy_d  = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        dut_a_d = busy_d & idx_d[1];
        dut_b_d = busy_d & idx_d[0];
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gate_q  <= 3'd0;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            y_q     <= 4'b0000;
            fm_q    <= 4'b0000;
            err_q   <= 3'd0;
            pass_q  <= 1'b0;
            dut_a_q <= 1'b0;
            dut_b_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            fm_q    <= fm_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            dut_a_q <= dut_a_d;
            dut_b_q <= dut_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dut_a     = dut_a_q;
    assign dut_b     = dut_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign y_table   = y_q;
    assign fail_mask = fm_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_logic_gate_checker.sv
// Bench for logic_gate_checker: two builds (settle 4 and settle 1) driven
// against behavioural gate models, results scored through a queue.
module tb_logic_gate_checker;

    localparam int S0 = 4;
    localparam int S1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start0, start1;
    logic [2:0] gsel0, gsel1;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [3:0] yt0, fm0, yt1, fm1;
    logic [2:0] ec0, ec1;
    logic       cen0, cval0, cen1, cval1;
    logic [2:0] mg0, mg1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] y;
        logic [3:0] fm;
        logic [2:0] ec;
        logic       pass;
    } exp_t;
    exp_t sb[$];

    function automatic logic gate_fn(input logic [2:0] g, input logic a, input logic b);
        case (g)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    function automatic logic [3:0] tt(input logic [2:0] g);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            r[i] = gate_fn(g, ab[1], ab[0]);
        end
        return r;
    endfunction

    assign y0 = cen0 ? cval0 : gate_fn(mg0, a0, b0);
    assign y1 = cen1 ? cval1 : gate_fn(mg1, a1, b1);

    logic_gate_checker #(.SETTLE_CYCLES(S0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .gate_sel(gsel0),
        .dut_a(a0), .dut_b(b0), .dut_y(y0), .busy(busy0), .done(done0),
        .pass(pass0), .y_table(yt0), .fail_mask(fm0), .err_count(ec0)
    );

    logic_gate_checker #(.SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .gate_sel(gsel1),
        .dut_a(a1), .dut_b(b1), .dut_y(y1), .busy(busy1), .done(done1),
        .pass(pass1), .y_table(yt1), .fail_mask(fm1), .err_count(ec1)
    );

    // {a,b,busy,done,pass,y_table,fail_mask,err_count}
    function automatic logic [15:0] outs(input bit inst);
        if (inst) return {a1, b1, busy1, done1, pass1, yt1, fm1, ec1};
        return {a0, b0, busy0, done0, pass0, yt0, fm0, ec0};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit inst, input logic v);
        if (inst) start1 = v; else start0 = v;
    endtask

    task automatic set_gsel(input bit inst, input logic [2:0] g);
        if (inst) gsel1 = g; else gsel0 = g;
    endtask

    task automatic run(input bit inst, input logic [2:0] gate, input bit cen,
                       input logic cval, input logic [2:0] mgate,
                       input int restart_at, input logic [2:0] new_gate,
                       input int abort_at, input string tag);
        int s, lat, n, done_at, seq_err, dn, vi;
        logic [15:0] o, o_hold;
        logic [1:0] ev;
        exp_t e;
        s   = inst ? S1 : S0;
        lat = 4 * (s + 1);
        if (inst) begin cen1 = cen; cval1 = cval; mg1 = mgate; end
        else      begin cen0 = cen; cval0 = cval; mg0 = mgate; end

        @(negedge clk);
        set_gsel(inst, gate);
        set_start(inst, 1'b1);
        e.y    = cen ? {4{cval}} : tt(mgate);
        e.fm   = e.y ^ tt(gate);
        e.ec   = 3'($countones(e.fm));
        e.pass = (e.ec == 3'd0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        set_start(inst, 1'b0);

        n = 0; done_at = -1; seq_err = 0;
        while (done_at < 0 && n < 200) begin
            o = outs(inst);
            if (n < lat) begin
                vi = n / (s + 1);
                ev = 2'(vi);
                if (o[15:14] != ev || !o[13] || o[12]) seq_err++;
            end
            if (o[12]) begin
                done_at = n;
            end else begin
                if (n == restart_at) begin
                    set_start(inst, 1'b1);
                    set_gsel(inst, new_gate);
                end
                if (n == abort_at) begin
                    rst = 1'b1;
                    #2;
                    chk({tag, "_rst_async"}, int'(outs(inst)), 0);
                    chk({tag, "_abort_seq"}, seq_err, 0);
                    repeat (2) @(posedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    dn = 0;
                    repeat (25) begin
                        @(posedge clk);
                        #1;
                        o = outs(inst);
                        if (o[12] || o[13]) dn++;
                    end
                    chk({tag, "_no_done_after_abort"}, dn, 0);
                    void'(sb.pop_front());
                    return;
                end
                @(posedge clk);
                #1;
                set_start(inst, 1'b0);
                n++;
            end
        end

        chk({tag, "_done_edge"}, done_at, lat);
        chk({tag, "_ab_seq"}, seq_err, 0);
        o = outs(inst);
        chk({tag, "_busy_in_done"}, int'(o[13]), 0);
        chk({tag, "_ab_in_done"}, int'(o[15:14]), 0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_y_table"}, int'(o[10:7]), int'(e.y));
            chk({tag, "_fail_mask"}, int'(o[6:3]), int'(e.fm));
            chk({tag, "_err_count"}, int'(o[2:0]), int'(e.ec));
            chk({tag, "_pass"}, int'(o[11]), int'(e.pass));
        end
        o_hold = o;
        @(posedge clk);
        #1;
        o = outs(inst);
        chk({tag, "_done_pulse"}, int'(o[12]), 0);
        repeat (2) @(posedge clk);
        #1;
        o = outs(inst);
        chk({tag, "_hold"}, int'(o[11:0]), int'({o_hold[11], o_hold[10:0]}) & 32'h0FFF & ~32'h1000);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        gsel0 = 3'd0; gsel1 = 3'd0;
        cen0 = 1'b0; cval0 = 1'b0; mg0 = 3'd0;
        cen1 = 1'b0; cval1 = 1'b0; mg1 = 3'd0;
        #22;
        chk("reset_outs0", int'(outs(1'b0)), 0);
        chk("reset_outs1", int'(outs(1'b1)), 0);
        @(negedge clk);
        rst = 1'b0;

        run(1'b0, 3'd4, 1'b0, 1'b0, 3'd4, -1, 3'd0, -1, "xor_basic");
        run(1'b0, 3'd0, 1'b1, 1'b1, 3'd0, -1, 3'd0, -1, "and_stuck1");
        for (int g = 0; g < 8; g++) begin
            run(1'b0, 3'(g), 1'b0, 1'b0, 3'(g), -1, 3'd0, -1, $sformatf("match_g%0d", g));
        end
        run(1'b0, 3'd4, 1'b0, 1'b0, 3'd4, 7, 3'd0, -1, "restart_ignored");
        run(1'b0, 3'd7, 1'b1, 1'b0, 3'd0, -1, 3'd0, -1, "buf_stuck0");
        run(1'b0, 3'd1, 1'b0, 1'b0, 3'd3, -1, 3'd0, -1, "or_vs_nor");
        run(1'b0, 3'd2, 1'b0, 1'b0, 3'd2, -1, 3'd0, 10, "abort");
        run(1'b0, 3'd2, 1'b0, 1'b0, 3'd2, -1, 3'd0, -1, "after_abort");
        run(1'b1, 3'd5, 1'b0, 1'b0, 3'd5, -1, 3'd0, -1, "xnor_s1");
        run(1'b1, 3'd6, 1'b0, 1'b0, 3'd7, -1, 3'd0, -1, "nota_s1_bad");

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_gate_checker.md
LOGIC_GATE_CHECKER -- requirements
Module: logic_gate_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, meaning: cycles each stimulus vector is held before the DUT output is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request one exhaustive test run; accepted only in IDLE.
REQ-005 gate_sel  input  3  gate under test: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(A), 7 BUF(A).
REQ-006 dut_a  output  1  stimulus A to the DUT.
REQ-007 dut_b  output  1  stimulus B to the DUT.
REQ-008 dut_y  input  1  DUT output Y, sampled by this block.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  single-cycle pulse at end of run.
REQ-011 pass  output  1  1 when the last run had zero mismatches; held until the next accepted start.
REQ-012 y_table  output  4  observed Y per vector; bit index = {A,B}.
REQ-013 fail_mask  output  4  y_table XOR expected table; bit set = mismatch on that vector.
REQ-014 err_count  output  3  number of mismatching vectors (0..4).

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 IDLE: start=1 at an edge SHALL latch gate_sel, clear y_table, fail_mask, err_count and pass, set vector index to 0, and enter SETTLE.
REQ-017 dut_a/dut_b SHALL equal index[1]/index[0] in SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles (settle counter reset on entry), then go to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle; at its closing edge y_table[index] := dut_y, fail_mask[index] := dut_y XOR expected[index], err_count increments on mismatch.
REQ-020 After SAMPLE, index<3 SHALL increment index and re-enter SETTLE; index=3 SHALL enter DONE.
REQ-021 DONE SHALL last one cycle with done=1, pass = (err_count==0) including the final sample, then return to IDLE.
REQ-022 busy SHALL be 1 in SETTLE and SAMPLE, 0 in IDLE and DONE.
REQ-023 Latency: done SHALL be high in the cycle starting exactly 4*(SETTLE_CYCLES+1) edges after the edge that accepted start (20 for default).
REQ-024 start while not in IDLE (including in DONE) SHALL be ignored; gate_sel changes during a run SHALL have no effect.
REQ-025 Expected tables ({A,B}=3..0 as bits 3..0): AND 1000, OR 1110, NAND 0111, NOR 0001, XOR 0110, XNOR 1001, NOT(A) 0011, BUF(A) 1100.
REQ-026 err_count SHALL saturate at 4 by construction (exactly one compare per vector) and never wrap.
REQ-027 Result outputs (pass, y_table, fail_mask, err_count) SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-028 rst=1 SHALL immediately, independent of clk, force IDLE, index 0, settle counter 0, dut_a=dut_b=0, busy=0, done=0, pass=0, y_table=0, fail_mask=0, err_count=0.
REQ-029 rst asserted mid-run SHALL abort the run with no done pulse; the first start after rst deasserts SHALL begin a fresh run.

Structure
REQ-030 A shared package SHALL hold the gate_sel encodings, the eight 4-bit expected truth-table constants, and the FSM state enumeration.
REQ-031 Expected-value lookup SHALL be a sub-module gate_truth_rom (gate_sel in, 4-bit table out, combinational); the FSM, counters and result registers SHALL stay in logic_gate_checker.

Verification
REQ-032 gate_sel=4 with a correct XOR model on dut_y, start pulse -> done at edge 20, pass=1, y_table=0110, fail_mask=0000, err_count=0.
REQ-033 gate_sel=0 with dut_y tied to 1 -> y_table=1111, fail_mask=0111, err_count=3, pass=0.
REQ-034 All eight gate_sel values against matching models -> pass=1 each run; dut_a/dut_b step through 00,01,10,11, each held SETTLE_CYCLES+1 cycles.
REQ-035 start re-pulsed at cycle 7 and gate_sel changed mid-run -> no restart, results reflect the latched gate, done still at edge 20.
REQ-036 rst asserted at cycle 10, released, start again -> outputs return to reset values without clk, no done from the aborted run, second run completes normally.
REQ-037 SETTLE_CYCLES=1 build, XNOR model -> done at edge 8, y_table=1001, pass=1.
